// File: rtl/ring_pkg.sv
// Shared flit layout and transmit-arbiter state encoding for the ring station.
package ring_pkg;

   localparam int FLIT_W   = 34;
   localparam int TAIL_BIT = FLIT_W - 1;
   localparam int HEAD_BIT = FLIT_W - 2;

   typedef struct packed {
      logic                tail;
      logic                head;
      logic [FLIT_W-3:0]   payload;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RING_PKT = 2'd1,
      LOC_PKT  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/ring_tx_arb.sv
// Pops ring pass-through and local injection buffers with packet-atomic,
// starvation-protected arbitration and feeds the outgoing link through one register.
module ring_tx_arb
   import ring_pkg::*;
#(
   parameter int WIDTH      = FLIT_W,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iRingEmpty,
   input  logic [WIDTH-1:0] iRingDat,
   output logic             oRingRdEn,
   input  logic             iLocEmpty,
   input  logic [WIDTH-1:0] iLocDat,
   output logic             oLocRdEn,
   input  logic             iDnFul,
   output logic             oDnWrEn,
   output logic [WIDTH-1:0] oDnWrDat,
   output logic             oBusy,
   output logic             oProtoErr
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   tx_state_e        state;
   logic             outVld;
   logic [WIDTH-1:0] outDat;
   logic [3:0]       starveCnt;
   logic             protoErr;

   logic             dnWrEn;
   logic             slotFree;
   logic             ringWins;
   logic             ringRd;
   logic             locRd;
   logic             pop;
   logic [WIDTH-1:0] popDat;

   // Pop selection: grant in IDLE, owner-only pops inside a packet.
   always_comb begin
      ringRd   = 1'b0;
      locRd    = 1'b0;
      dnWrEn   = outVld & ~iDnFul;
      slotFree = ~outVld | dnWrEn;
      ringWins = ~iRingEmpty & (iLocEmpty | (starveCnt < STARVE_LIM));
      // Upstream buffers share this reset, so nothing is popped while it is held.
      if (rst && slotFree) begin
         case (state)
            IDLE: begin
               ringRd = ringWins;
               locRd  = ~ringWins & ~iLocEmpty;
            end
            RING_PKT: begin
               ringRd = ~iRingEmpty;
            end
            LOC_PKT: begin
               locRd = ~iLocEmpty;
            end
            default: begin
               ringRd = 1'b0;
               locRd  = 1'b0;
            end
         endcase
      end else begin
         ringRd = 1'b0;
         locRd  = 1'b0;
      end
      pop    = ringRd | locRd;
      popDat = ringRd ? iRingDat : iLocDat;
   end

   // Packet FSM, output register, starvation counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         outVld    <= 1'b0;
         outDat    <= '0;
         starveCnt <= 4'd0;
         protoErr  <= 1'b0;
      end else begin
         if (pop) begin
            outVld <= 1'b1;
            outDat <= popDat;
         end else if (dnWrEn) begin
            outVld <= 1'b0;
         end

         if (pop) begin
            if (popDat[WIDTH-1]) begin
               state <= IDLE;
            end else begin
               state <= ringRd ? RING_PKT : LOC_PKT;
            end
            // Head expected exactly when no packet is open.
            if ((state == IDLE) != popDat[WIDTH-2]) begin
               protoErr <= 1'b1;
            end
         end

         if (pop && (state == IDLE)) begin
            if (ringRd && !iLocEmpty) begin
               starveCnt <= (starveCnt >= STARVE_LIM) ? STARVE_LIM : starveCnt + 4'd1;
            end else begin
               starveCnt <= 4'd0;
            end
         end
      end
   end

   assign oRingRdEn = ringRd;
   assign oLocRdEn  = locRd;
   assign oDnWrEn   = dnWrEn;
   assign oDnWrDat  = outDat;
   assign oBusy     = (state != IDLE);
   assign oProtoErr = protoErr;

endmodule

// File: tb/tb_ring_tx_arb.sv
// Self-checking bench for ring_tx_arb: directed scenarios plus randomized packet
// mixes compared against a packet-level arbitration model.
module tb_ring_tx_arb;
   import ring_pkg::*;

   localparam int W  = FLIT_W;
   localparam int SM = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         iRingEmpty, iLocEmpty, iDnFul;
   logic [W-1:0] iRingDat, iLocDat;
   logic         oRingRdEn, oLocRdEn, oDnWrEn, oBusy, oProtoErr;
   logic [W-1:0] oDnWrDat;

   ring_tx_arb #(.WIDTH(W), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .iRingEmpty(iRingEmpty), .iRingDat(iRingDat), .oRingRdEn(oRingRdEn),
      .iLocEmpty(iLocEmpty), .iLocDat(iLocDat), .oLocRdEn(oLocRdEn),
      .iDnFul(iDnFul), .oDnWrEn(oDnWrEn), .oDnWrDat(oDnWrDat),
      .oBusy(oBusy), .oProtoErr(oProtoErr)
   );

   always #5 clk = ~clk;

   // Upstream buffers, downstream capture and model state.
   logic [W-1:0] ringQ[$], locQ[$], rxQ[$], expQ[$];
   logic [W-1:0] mRing[$], mLoc[$];
   int           mRLen[$], mLLen[$];
   int           modelCnt = 0;
   int           nAssert = 0, nFail = 0;
   logic         sRr, sLr, sWe;
   logic [W-1:0] sWd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mkFlit(input logic hd, input logic tl, input logic [W-3:0] pl);
      flit_t f;
      f.tail    = tl;
      f.head    = hd;
      f.payload = pl;
      return f;
   endfunction

   // One clock: present buffer heads, sample mid-cycle, then apply pops/writes at the edge.
   task automatic tick();
      iRingEmpty = (ringQ.size() == 0);
      iLocEmpty  = (locQ.size() == 0);
      iRingDat   = iRingEmpty ? '0 : ringQ[0];
      iLocDat    = iLocEmpty  ? '0 : locQ[0];
      #2;
      sRr = oRingRdEn;
      sLr = oLocRdEn;
      sWe = oDnWrEn;
      sWd = oDnWrDat;
      chk("both_pop", sRr & sLr, 1'b0);
      chk("ring_empty_pop", sRr & iRingEmpty, 1'b0);
      chk("loc_empty_pop", sLr & iLocEmpty, 1'b0);
      chk("wr_when_full", sWe & iDnFul, 1'b0);
      @(posedge clk);
      if (sRr && ringQ.size() > 0) void'(ringQ.pop_front());
      if (sLr && locQ.size() > 0) void'(locQ.pop_front());
      if (sWe) rxQ.push_back(sWd);
      #1;
   endtask

   task automatic addPkt(input bit toRing, input int len);
      logic [W-1:0] f;
      for (int i = 0; i < len; i++) begin
         f = mkFlit(i == 0, i == len - 1, W'($urandom));
         if (toRing) begin
            ringQ.push_back(f);
            mRing.push_back(f);
         end else begin
            locQ.push_back(f);
            mLoc.push_back(f);
         end
      end
      if (toRing) mRLen.push_back(len);
      else        mLLen.push_back(len);
   endtask

   // Packet-level arbitration over preloaded sources.
   task automatic modelRun();
      int n;
      bit takeRing;
      while (mRLen.size() > 0 || mLLen.size() > 0) begin
         takeRing = (mRLen.size() > 0) && (mLLen.size() == 0 || modelCnt < SM);
         if (takeRing) begin
            modelCnt = (mLLen.size() > 0) ? ((modelCnt + 1 > SM) ? SM : modelCnt + 1) : 0;
            n = mRLen.pop_front();
            for (int i = 0; i < n; i++) expQ.push_back(mRing.pop_front());
         end else begin
            modelCnt = 0;
            n = mLLen.pop_front();
            for (int i = 0; i < n; i++) expQ.push_back(mLoc.pop_front());
         end
      end
   endtask

   task automatic drainCheck(input string tag, input bit randFul);
      for (int c = 0; c < 600 && rxQ.size() < expQ.size(); c++) begin
         iDnFul = randFul ? ($urandom_range(0, 3) == 0) : 1'b0;
         tick();
      end
      iDnFul = 1'b0;
      tick();
      tick();
      chk({tag, "_count"}, rxQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
         chk({tag, "_flit"}, rxQ[i], expQ[i]);
      rxQ.delete();
      expQ.delete();
   endtask

   task automatic doReset();
      rst = 1'b0;
      tick();
      ringQ.delete();
      locQ.delete();
      tick();
      rxQ.delete();
      rst = 1'b1;
      modelCnt = 0;
   endtask

   initial begin
      logic [W-1:0] f1, hd, bf;
      int nR, nL;
      rst = 1'b0; iDnFul = 1'b0;
      iRingEmpty = 1'b1; iLocEmpty = 1'b1; iRingDat = '0; iLocDat = '0;
      @(posedge clk); #1;
      doReset();
      chk("rst_wren", oDnWrEn, 1'b0);
      chk("rst_busy", oBusy, 1'b0);
      chk("rst_err", oProtoErr, 1'b0);
      chk("rst_dat", oDnWrDat, '0);

      // Local single flit, ring empty.
      f1 = 34'h3_00000011;
      locQ.push_back(f1);
      tick();
      chk("loc_pop", sLr, 1'b1);
      chk("loc_no_ring", sRr, 1'b0);
      tick();
      chk("loc_wr", sWe, 1'b1);
      chk("loc_dat", sWd, f1);
      chk("loc_pop_once", sLr, 1'b0);
      chk("loc_err", oProtoErr, 1'b0);
      rxQ.delete();

      // Ring 3-flit packet and local flit together: no interleave.
      addPkt(1'b1, 3);
      addPkt(1'b0, 1);
      modelCnt = 0;
      modelRun();
      tick();
      chk("ring_first", sRr, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("b2b_wr", sWe, 1'b1);
      end
      drainCheck("atomic", 1'b0);

      // Downstream full for 5 cycles mid ring packet.
      addPkt(1'b1, 4);
      modelRun();
      hd = ringQ[0];
      tick();
      iDnFul = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_no_pop", sRr, 1'b0);
         chk("hold_no_wr", sWe, 1'b0);
         chk("hold_dat", oDnWrDat, hd);
      end
      iDnFul = 1'b0;
      drainCheck("backpr", 1'b0);

      // Body flit popped in IDLE flags a protocol error but is still forwarded.
      bf = mkFlit(1'b0, 1'b1, 32'hBAD0_0001);
      ringQ.push_back(bf);
      tick();
      chk("perr_set", oProtoErr, 1'b1);
      tick();
      chk("perr_fwd", sWd, bf);
      chk("perr_fwd_wr", sWe, 1'b1);
      tick(); tick();
      chk("perr_sticky", oProtoErr, 1'b1);
      rxQ.delete();
      doReset();
      chk("perr_clr", oProtoErr, 1'b0);

      // Reset in the middle of a local packet.
      addPkt(1'b0, 3);
      mLoc.delete(); mLLen.delete();
      tick(); tick();
      chk("mid_busy", oBusy, 1'b1);
      rst = 1'b0;
      tick();
      ringQ.delete(); locQ.delete();
      chk("mid_rst_wr", oDnWrEn, 1'b0);
      chk("mid_rst_busy", oBusy, 1'b0);
      rst = 1'b1;
      rxQ.delete();
      modelCnt = 0;
      addPkt(1'b1, 2);
      modelRun();
      tick();
      chk("post_rst_grant", sRr, 1'b1);
      drainCheck("post_rst", 1'b0);

      // Directed starvation pattern: 10 ring singles vs 3 local singles.
      for (int i = 0; i < 10; i++) addPkt(1'b1, 1);
      for (int i = 0; i < 3; i++)  addPkt(1'b0, 1);
      modelRun();
      drainCheck("starve", 1'b0);

      // Randomized packet mixes with random backpressure.
      for (int s = 0; s < 30; s++) begin
         nR = $urandom_range(0, 8);
         nL = $urandom_range(0, 4);
         for (int i = 0; i < nR; i++) addPkt(1'b1, $urandom_range(1, 4));
         for (int i = 0; i < nL; i++) addPkt(1'b0, $urandom_range(1, 4));
         modelRun();
         drainCheck("rand", 1'b1);
         chk("rand_err", oProtoErr, 1'b0);
         chk("rand_idle", oBusy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/ring_tx_arb.md
Name: ring_tx_arb

Overview:
- Reader side of the ring station's two-register flit buffers.
- Pops flits from two upstream buffers: ring pass-through traffic and local injection.
- Arbitrates between them with packet atomicity and starvation protection.
- Drives the write side of the downstream outgoing-link buffer through a one-entry output register.

Parameters:
- WIDTH, 34: flit width. Bit WIDTH-1 = tail, bit WIDTH-2 = head, rest payload. Single-flit packet has head=tail=1.
- STARVE_MAX, 4: consecutive ring packets granted while local is non-empty before local is forced a grant. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- iRingEmpty  in  1  ring buffer empty
- iRingDat  in  WIDTH  ring buffer head flit, valid when !iRingEmpty
- oRingRdEn  out  1  pop ring buffer (combinational)
- iLocEmpty  in  1  local buffer empty
- iLocDat  in  WIDTH  local buffer head flit
- oLocRdEn  out  1  pop local buffer (combinational)
- iDnFul  in  1  downstream buffer full
- oDnWrEn  out  1  write downstream (combinational = outVld & !iDnFul)
- oDnWrDat  out  WIDTH  output register data
- oBusy  out  1  state != IDLE
- oProtoErr  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, outVld=0, oDnWrDat=0, starveCnt=0, oProtoErr=0.
  - Combinational outputs follow: oDnWrEn=0, oRingRdEn=0, oLocRdEn=0, oBusy=0.
  - Reset mid-packet abandons the packet; no flush. Upstream buffers are reset by the same rst.
- Output register:
  - slotFree = !outVld | oDnWrEn.
  - A pop loads the output register next cycle with outVld=1.
  - Otherwise, if oDnWrEn, outVld clears to 0.
  - Flit latency from pop to oDnWrEn: 1 cycle when iDnFul=0.
  - Full throughput: 1 flit/cycle.
- States: IDLE, RING_PKT, LOC_PKT.
- Grant in IDLE (evaluated every cycle slotFree=1):
  - Ring wins if !iRingEmpty and (iLocEmpty or starveCnt<STARVE_MAX).
  - Else local wins if !iLocEmpty.
  - The winner is popped in the same cycle.
- Transitions:
  - Popped flit has tail=1: stay IDLE (single-flit packet) or return to IDLE (packet end).
  - Popped flit has tail=0: go to, or remain in, RING_PKT/LOC_PKT.
- In RING_PKT/LOC_PKT:
  - Pop only the owning source, when it is non-empty and slotFree.
  - The other source is never popped.
  - An empty owner stalls the link (no interleave).
- starveCnt (updated on the head-flit pop in IDLE):
  - Ring grant with iLocEmpty=0: increment, saturating at STARVE_MAX.
  - Local grant: clear to 0.
  - Ring grant with local empty: clear to 0.
- Pop qualifiers:
  - Never pop an empty source.
  - oRingRdEn and oLocRdEn are never both high.
  - iDnFul=1 with outVld=1 means no pop that cycle.
- oProtoErr: set (sticky until reset) on either condition:
  - a flit with head=0 popped in IDLE;
  - a flit with head=1 popped in RING_PKT/LOC_PKT.
  - The offending flit is still forwarded. State follows its tail bit.
- Simultaneous events:
  - Drain and pop in the same cycle is allowed and keeps outVld=1.
  - Both sources non-empty in IDLE follows the grant rule above.

Decomposition:
- Package ring_pkg:
  - FLIT_W;
  - TAIL_BIT and HEAD_BIT index constants;
  - flit_t packed struct {tail, head, payload};
  - typedef enum logic[1:0] {IDLE, RING_PKT, LOC_PKT} tx_state_e.
- No sub-module; the output register is inline.
- Bench instantiates three existing two-register buffers (ring, local, downstream) around the block.

Test Plan:
- Reset, then local single flit 0x3_00000011 with ring empty, iDnFul=0 → oLocRdEn pulses 1 cycle; oDnWrEn=1 with oDnWrDat=0x3_00000011 the next cycle; oProtoErr=0.
- Ring 3-flit packet (H, body, T) and local 1-flit arrive together → ring flits output on 3 consecutive cycles, local flit on cycle 4; no interleave.
- STARVE_MAX=4: continuous ring single-flit packets, local always non-empty → pattern of 4 ring flits then 1 local flit, repeating; starveCnt never exceeds 4.
- iDnFul held 1 for 5 cycles during a ring packet → exactly one flit held in the output register, no pops; on release, flits resume in order, none lost or duplicated.
- Body flit (head=0, tail=1) popped in IDLE → flit forwarded, oProtoErr=1 and stays 1; a subsequent rst=0 clears it.
- rst=0 asserted mid local packet → next cycle oDnWrEn=0, oBusy=0; after rst=1, a new ring packet is granted normally.
